vga_char_blit: RTL and testbench

- Hardware text renderer upstream of the VGA controller, in the QClk domain.
- Takes character/clear commands from the core and turns each into 32-bit word writes into VGA frame memory (core-side write port).
- Frame memory is 1 bpp, 640x480. Each word covers 8 horizontal pixels x 4 lines; byte k holds line k, and bit i of a byte is pixel x = i, displayed leftmost first.
- Word address = (line>>2)*80 + (x>>3). One 8x8 glyph at text column c, row r maps to words (2r)*80+c (glyph lines 0-3) and (2r+1)*80+c (glyph lines 4-7). The text grid is 80x60.

---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vga_font_rom.sv | 16 +
 rtl/vga_char_blit.sv | 152 +++++++++++++++
 tb/tb_vga_char_blit.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the text blitter: geometry, FSM/op encodings and the
// built-in 8x8 font table used to fill the glyph ROM.
package vga_pkg;

  localparam int VGA_COLS      = 80;
  localparam int VGA_TEXT_ROWS = 60;
  localparam int VGA_FB_WORDS  = 9600;
  localparam int VGA_ADDR_W    = 14;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WR_TOP,
    WR_BOT,
    CLEAR
  } blit_state_t;

  typedef enum logic {
    OP_CHAR,
    OP_CLEAR
  } blit_op_t;

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Font table, bit7 = leftmost pixel. 'A' is a real glyph; every other code
  // gets a fixed, asymmetric filler pattern so each row is distinguishable.
  function automatic logic [7:0] font_row(input logic [7:0] code, input logic [2:0] line);
    logic [7:0] h;
    if (code == 8'h41) begin
      case (line)
        3'd0:    return 8'h18;
        3'd1:    return 8'h3C;
        3'd2:    return 8'h66;
        3'd3:    return 8'h66;
        3'd4:    return 8'h7E;
        3'd5:    return 8'h66;
        3'd6:    return 8'h66;
        default: return 8'h00;
      endcase
    end
    h = (code ^ 8'hA5) * 8'd13;
    h = h ^ ({5'd0, line} * 8'd57) ^ {line, code[4:0]};
    return h;
  endfunction

endpackage

// File: rtl/vga_font_rom.sv
// 2048x8 glyph ROM addressed by {char, line}; one cycle read latency.
module vga_font_rom
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);

  // NOTE: the ROM read register has no reset so it maps onto block ROM; its
  // contents only matter once FETCH has issued an address.
  always_ff @(posedge clk) begin
    data <= font_row(addr[10:3], addr[2:0]);
  end

endmodule

// File: rtl/vga_char_blit.sv
// Text renderer: turns CHAR/CLEAR commands into 32-bit word writes into the
// 1 bpp 640x480 frame memory (8 pixels x 4 lines per word).
module vga_char_blit
  import vga_pkg::*;
#(
  parameter int COLS     = VGA_COLS,
  parameter int ROWS     = VGA_TEXT_ROWS,
  parameter int FB_WORDS = VGA_FB_WORDS
) (
  input  logic                  QClk,
  input  logic                  Reset,
  input  logic                  CmdValid,
  output logic                  CmdReady,
  input  logic [1:0]            CmdOp,
  input  logic [7:0]            CmdChar,
  input  logic [6:0]            CmdCol,
  input  logic [5:0]            CmdRow,
  input  logic                  CmdInv,
  output logic                  VgaWrEn,
  input  logic                  VgaWrReady,
  output logic [VGA_ADDR_W-1:0] VgaWrAddr,
  output logic [31:0]           VgaWrData,
  output logic [3:0]            VgaWrByteEn,
  output logic                  Busy,
  output logic                  ErrOob
);

  blit_state_t state, state_nxt;
  blit_op_t    cmd_op;

  logic                  accept;
  logic                  in_range;
  logic                  xfer;
  logic                  clr_last;
  logic [7:0]            char_q;
  logic [6:0]            col_q;
  logic [5:0]            row_q;
  logic                  inv_q;
  logic [3:0]            line_cnt;
  logic [2:0]            slot;
  logic [VGA_ADDR_W-1:0] clr_cnt;
  logic [VGA_ADDR_W-1:0] top_addr;
  logic [63:0]           glyph;
  logic [10:0]           rom_addr;
  logic [7:0]            rom_data;
  logic                  err_oob_q;

  assign cmd_op   = (CmdOp == 2'd0) ? OP_CHAR : OP_CLEAR;
  assign in_range = (32'(CmdCol) < COLS) && (32'(CmdRow) < ROWS);
  assign accept   = CmdValid && CmdReady;
  assign xfer     = VgaWrEn && VgaWrReady;
  assign clr_last = (clr_cnt == VGA_ADDR_W'(FB_WORDS - 1));

  // Top word of glyph row r sits at band 2r: r*160 + c.
  assign top_addr = VGA_ADDR_W'(row_q) * VGA_ADDR_W'(2 * COLS) + VGA_ADDR_W'(col_q);

  // ROM data lags the issued line by one, so counter value n lands in slot n-1.
  assign slot     = 3'(line_cnt - 4'd1);
  assign rom_addr = {char_q, line_cnt[2:0]};

  vga_font_rom u_font_rom (
    .clk  (QClk),
    .addr (rom_addr),
    .data (rom_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge QClk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_op == OP_CLEAR) state_nxt = CLEAR;
          else if (in_range)      state_nxt = FETCH;
        end
      end
      FETCH:   if (line_cnt == 4'd8) state_nxt = WR_TOP;
      WR_TOP:  if (xfer) state_nxt = WR_BOT;
      WR_BOT:  if (xfer) state_nxt = IDLE;
      CLEAR:   if (xfer && clr_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge QClk or posedge Reset) begin
    if (Reset) begin
      char_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      inv_q     <= 1'b0;
      line_cnt  <= '0;
      clr_cnt   <= '0;
      glyph     <= '0;
      err_oob_q <= 1'b0;
    end else begin
      err_oob_q <= accept && (cmd_op == OP_CHAR) && !in_range;
      if (accept) begin
        char_q   <= CmdChar;
        col_q    <= CmdCol;
        row_q    <= CmdRow;
        inv_q    <= CmdInv;
        line_cnt <= '0;
        clr_cnt  <= '0;
      end
      if (state == FETCH) begin
        line_cnt <= line_cnt + 4'd1;
        if (line_cnt != 4'd0)
          glyph[{slot, 3'b000} +: 8] <= bit_rev8(rom_data) ^ {8{inv_q}};
      end
      if (state == CLEAR && xfer)
        clr_cnt <= clr_last ? '0 : clr_cnt + VGA_ADDR_W'(1);
    end
  end

  // NOTE: every output gets a default first so this block can never infer a latch.
  always_comb begin
    VgaWrEn     = 1'b0;
    VgaWrAddr   = '0;
    VgaWrData   = '0;
    VgaWrByteEn = 4'h0;
    case (state)
      WR_TOP: begin
        VgaWrEn   = 1'b1;
        VgaWrAddr = top_addr;
        VgaWrData = glyph[31:0];
      end
      WR_BOT: begin
        VgaWrEn   = 1'b1;
        VgaWrAddr = top_addr + VGA_ADDR_W'(COLS);
        VgaWrData = glyph[63:32];
      end
      CLEAR: begin
        VgaWrEn   = 1'b1;
        VgaWrAddr = clr_cnt;
        VgaWrData = {32{inv_q}};
      end
      default: ;
    endcase
    if (VgaWrEn) VgaWrByteEn = 4'hF;
  end

  assign CmdReady = (state == IDLE) && !Reset;
  assign Busy     = (state != IDLE);
  assign ErrOob   = err_oob_q;

endmodule

// File: tb/tb_vga_char_blit.sv
// Self-checking bench for vga_char_blit: pixel-level reference model, write
// monitor, and scenario tasks for timing, stalls, clears, resets and streaming.
module tb_vga_char_blit;
  import vga_pkg::*;

  logic        QClk = 1'b0;
  logic        Reset;
  logic        CmdValid;
  logic        CmdReady;
  logic [1:0]  CmdOp;
  logic [7:0]  CmdChar;
  logic [6:0]  CmdCol;
  logic [5:0]  CmdRow;
  logic        CmdInv;
  logic        VgaWrEn;
  logic        VgaWrReady;
  logic [13:0] VgaWrAddr;
  logic [31:0] VgaWrData;
  logic [3:0]  VgaWrByteEn;
  logic        Busy;
  logic        ErrOob;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int ready_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 held low
  int be_bad = 0;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] data;
    int          edge_n;
  } wr_t;
  wr_t wq[$];

  vga_char_blit dut (
    .QClk        (QClk),
    .Reset       (Reset),
    .CmdValid    (CmdValid),
    .CmdReady    (CmdReady),
    .CmdOp       (CmdOp),
    .CmdChar     (CmdChar),
    .CmdCol      (CmdCol),
    .CmdRow      (CmdRow),
    .CmdInv      (CmdInv),
    .VgaWrEn     (VgaWrEn),
    .VgaWrReady  (VgaWrReady),
    .VgaWrAddr   (VgaWrAddr),
    .VgaWrData   (VgaWrData),
    .VgaWrByteEn (VgaWrByteEn),
    .Busy        (Busy),
    .ErrOob      (ErrOob)
  );

  always #5 QClk = ~QClk;
  always @(posedge QClk) cyc <= cyc + 1;

  always @(posedge QClk) begin
    #2;
    case (ready_mode)
      0:       VgaWrReady = 1'b1;
      1:       VgaWrReady = ~VgaWrReady;
      2:       VgaWrReady = 1'($urandom_range(0, 1));
      default: VgaWrReady = 1'b0;
    endcase
  end

  // Records each transfer half a cycle before the edge that completes it.
  always @(negedge QClk) begin
    if (!Reset) begin
      if (VgaWrEn && VgaWrReady) wq.push_back('{VgaWrAddr, VgaWrData, cyc + 1});
      if (VgaWrByteEn !== (VgaWrEn ? 4'hF : 4'h0)) be_bad++;
    end
  end

  // Pixel x of glyph line n is font bit (7-x); word byte k holds line base+k.
  function automatic logic [31:0] exp_word(input logic [7:0] code, input int base, input logic inv);
    logic [31:0] w;
    logic [7:0]  f;
    for (int n = 0; n < 4; n++) begin
      f = font_row(code, 3'(base + n));
      for (int x = 0; x < 8; x++) w[8*n + x] = f[7-x] ^ inv;
    end
    return w;
  endfunction

  function automatic int exp_addr(input int col, input int row, input int half);
    int px, ln;
    px = col * 8;
    ln = row * 8 + half * 4;
    return (ln >> 2) * 80 + (px >> 3);
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] code, input int col,
                          input int row, input logic inv, output int acc);
    bit got;
    CmdOp = op; CmdChar = code; CmdCol = 7'(col); CmdRow = 6'(row); CmdInv = inv;
    CmdValid = 1'b1;
    got = 0;
    for (int i = 0; i < 30000; i++) begin
      @(negedge QClk);
      if (CmdReady) begin got = 1; break; end
    end
    @(posedge QClk); #1;
    acc = cyc;
    CmdValid = 1'b0;
    if (!got) begin
      total++;
      $display("FAIL send_cmd: CmdReady never rose, got 0 required 1");
    end
  endtask

  task automatic wait_idle(input int budget, output int done_edge);
    done_edge = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge QClk); #1;
      if (!Busy) begin done_edge = cyc; break; end
    end
    if (done_edge < 0) begin
      total++;
      $display("FAIL wait_idle: Busy still 1 after %0d cycles, required 0", budget);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; CmdValid = 1'b0; CmdOp = 2'd0; CmdChar = 8'h0;
    CmdCol = 7'd0; CmdRow = 6'd0; CmdInv = 1'b0;
    repeat (3) @(posedge QClk);
    #1;
    total++; if ({VgaWrEn, Busy, ErrOob} !== 3'b000) $display("FAIL reset_flags: got %b required 000", {VgaWrEn, Busy, ErrOob}); else passed++;
    total++; if (VgaWrAddr !== 14'd0) $display("FAIL reset_addr: got %0d required 0", VgaWrAddr); else passed++;
    total++; if (VgaWrData !== 32'd0) $display("FAIL reset_data: got %h required 0", VgaWrData); else passed++;
    total++; if (VgaWrByteEn !== 4'h0) $display("FAIL reset_byteen: got %h required 0", VgaWrByteEn); else passed++;
    #2 Reset = 1'b0;
    #1;
    total++; if (CmdReady !== 1'b1) $display("FAIL reset_ready: got %b required 1", CmdReady); else passed++;
  endtask

  task automatic test_char_basic();
    int acc, rise, done;
    ready_mode = 0;
    @(posedge QClk); #1;
    wq.delete();
    send_cmd(2'd0, 8'h41, 0, 0, 1'b0, acc);
    rise = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge QClk); #1;
      if (VgaWrEn) begin rise = cyc; break; end
    end
    total++; if (rise - acc !== 9) $display("FAIL basic_wren_rise: got %0d edges after accept required 9", rise - acc); else passed++;
    wait_idle(20, done);
    total++; if (done - acc !== 11) $display("FAIL basic_busy_drop: got %0d edges after accept required 11", done - acc); else passed++;
    total++; if (wq.size() !== 2) $display("FAIL basic_count: got %0d writes required 2", wq.size()); else passed++;
    if (wq.size() >= 2) begin
      total++; if (wq[0].addr !== 14'(exp_addr(0, 0, 0))) $display("FAIL basic_addr_top: got %0d required %0d", wq[0].addr, exp_addr(0, 0, 0)); else passed++;
      total++; if (wq[0].data !== exp_word(8'h41, 0, 1'b0)) $display("FAIL basic_data_top: got %h required %h", wq[0].data, exp_word(8'h41, 0, 1'b0)); else passed++;
      total++; if (wq[1].addr !== 14'(exp_addr(0, 0, 1))) $display("FAIL basic_addr_bot: got %0d required %0d", wq[1].addr, exp_addr(0, 0, 1)); else passed++;
      total++; if (wq[1].data !== exp_word(8'h41, 4, 1'b0)) $display("FAIL basic_data_bot: got %h required %h", wq[1].data, exp_word(8'h41, 4, 1'b0)); else passed++;
    end
  endtask

  task automatic test_corner_inv();
    int acc, done;
    logic [7:0] code;
    code = 8'($urandom);
    wq.delete();
    send_cmd(2'd0, code, 79, 59, 1'b1, acc);
    wait_idle(30, done);
    total++; if (wq.size() !== 2) $display("FAIL corner_count: got %0d writes required 2", wq.size()); else passed++;
    if (wq.size() >= 2) begin
      total++; if (wq[0].addr !== 14'(exp_addr(79, 59, 0))) $display("FAIL corner_addr_top: got %0d required %0d", wq[0].addr, exp_addr(79, 59, 0)); else passed++;
      total++; if (wq[0].data !== exp_word(code, 0, 1'b1)) $display("FAIL corner_data_top: got %h required %h", wq[0].data, exp_word(code, 0, 1'b1)); else passed++;
      total++; if (wq[1].addr !== 14'(exp_addr(79, 59, 1))) $display("FAIL corner_addr_bot: got %0d required %0d", wq[1].addr, exp_addr(79, 59, 1)); else passed++;
      total++; if (wq[1].data !== exp_word(code, 4, 1'b1)) $display("FAIL corner_data_bot: got %h required %h", wq[1].data, exp_word(code, 4, 1'b1)); else passed++;
    end
  endtask

  task automatic test_oob();
    int cols[3], rows[3];
    int acc, bad;
    cols[0] = 80;                      rows[0] = int'($urandom_range(0, 59));
    cols[1] = int'($urandom_range(0, 79)); rows[1] = 60;
    cols[2] = 127;                     rows[2] = 63;
    for (int k = 0; k < 3; k++) begin
      wq.delete();
      send_cmd(2'd0, 8'($urandom), cols[k], rows[k], 1'($urandom_range(0, 1)), acc);
      total++; if (ErrOob !== 1'b1) $display("FAIL oob%0d_pulse: got %b required 1", k, ErrOob); else passed++;
      @(posedge QClk); #1;
      total++; if (ErrOob !== 1'b0) $display("FAIL oob%0d_pulse_end: got %b required 0", k, ErrOob); else passed++;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
        if (CmdReady !== 1'b1 || Busy !== 1'b0 || VgaWrEn !== 1'b0 || ErrOob !== 1'b0) bad++;
        @(posedge QClk); #1;
      end
      total++; if (bad !== 0) $display("FAIL oob%0d_idle: got %0d non-idle cycles required 0", k, bad); else passed++;
      total++; if (wq.size() !== 0) $display("FAIL oob%0d_nowrite: got %0d writes required 0", k, wq.size()); else passed++;
    end
  endtask

  task automatic test_stall();
    int acc, rise, bad, col, row, seen;
    logic [7:0]  code;
    logic        inv;
    logic [13:0] a0;
    logic [31:0] d0;
    code = 8'($urandom); col = int'($urandom_range(0, 79)); row = int'($urandom_range(0, 59));
    inv = 1'($urandom_range(0, 1));
    ready_mode = 3;
    wq.delete();
    send_cmd(2'd0, code, col, row, inv, acc);
    rise = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge QClk); #1;
      if (VgaWrEn) begin rise = cyc; break; end
    end
    total++; if (rise - acc !== 9) $display("FAIL stall_wren_rise: got %0d required 9", rise - acc); else passed++;
    a0 = VgaWrAddr; d0 = VgaWrData;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge QClk); #1;
      if (VgaWrAddr !== a0 || VgaWrData !== d0 || VgaWrEn !== 1'b1 || CmdReady !== 1'b0) bad++;
    end
    total++; if (bad !== 0) $display("FAIL stall_hold: got %0d unstable cycles required 0", bad); else passed++;
    ready_mode = 0;
    seen = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge QClk); #1;
      if (CmdReady) begin seen = wq.size(); break; end
    end
    total++; if (seen !== 2) $display("FAIL stall_ready_after: got %0d writes when ready rose required 2", seen); else passed++;
    if (wq.size() == 2) begin
      total++; if (wq[0].addr !== 14'(exp_addr(col, row, 0)) || wq[0].data !== exp_word(code, 0, inv))
        $display("FAIL stall_top: got %0d/%h required %0d/%h", wq[0].addr, wq[0].data, exp_addr(col, row, 0), exp_word(code, 0, inv)); else passed++;
      total++; if (wq[1].addr !== 14'(exp_addr(col, row, 1)) || wq[1].data !== exp_word(code, 4, inv))
        $display("FAIL stall_bot: got %0d/%h required %0d/%h", wq[1].addr, wq[1].data, exp_addr(col, row, 1), exp_word(code, 4, inv)); else passed++;
    end
  endtask

  task automatic test_clear();
    int acc, done, bad, first;
    ready_mode = 1;
    wq.delete();
    send_cmd(2'd1, 8'h00, 0, 0, 1'b0, acc);
    wait_idle(25000, done);
    total++; if (wq.size() !== 9600) $display("FAIL clear0_count: got %0d required 9600", wq.size()); else passed++;
    bad = 0; first = -1;
    foreach (wq[i]) if (wq[i].addr !== 14'(i) || wq[i].data !== 32'h0) begin bad++; if (first < 0) first = i; end
    total++; if (bad !== 0) $display("FAIL clear0_seq: got %0d bad words (first %0d) required 0", bad, first); else passed++;

    ready_mode = 0;
    @(posedge QClk); #1;
    wq.delete();
    send_cmd(2'd3, 8'h00, 0, 0, 1'b1, acc);
    wait_idle(12000, done);
    total++; if (done - acc !== 9600) $display("FAIL clear1_cycles: got %0d required 9600", done - acc); else passed++;
    total++; if (wq.size() !== 9600) $display("FAIL clear1_count: got %0d required 9600", wq.size()); else passed++;
    bad = 0; first = -1;
    foreach (wq[i]) if (wq[i].addr !== 14'(i) || wq[i].data !== 32'hFFFF_FFFF) begin bad++; if (first < 0) first = i; end
    total++; if (bad !== 0) $display("FAIL clear1_seq: got %0d bad words (first %0d) required 0", bad, first); else passed++;
  endtask

  task automatic test_reset_mid();
    int acc, n, reached;
    ready_mode = 0;
    wq.delete();
    send_cmd(2'd0, 8'($urandom), int'($urandom_range(0, 79)), int'($urandom_range(0, 59)), 1'b0, acc);
    repeat (4) @(posedge QClk);
    #3 Reset = 1'b1;
    #1;
    total++; if ({VgaWrEn, Busy} !== 2'b00) $display("FAIL rst_fetch_now: got %b required 00", {VgaWrEn, Busy}); else passed++;
    repeat (2) @(posedge QClk);
    #3 Reset = 1'b0;
    #1;
    total++; if (CmdReady !== 1'b1) $display("FAIL rst_fetch_ready: got %b required 1", CmdReady); else passed++;
    repeat (15) @(posedge QClk);
    #1;
    total++; if (wq.size() !== 0) $display("FAIL rst_fetch_nowrite: got %0d writes required 0", wq.size()); else passed++;

    send_cmd(2'd1, 8'h00, 0, 0, 1'b0, acc);
    reached = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge QClk); #1;
      if (wq.size() >= 500) begin reached = 1; break; end
    end
    total++; if (reached !== 1) $display("FAIL rst_clear_progress: got %0d writes required 500", wq.size()); else passed++;
    #2 Reset = 1'b1;
    #1;
    total++; if (VgaWrEn !== 1'b0) $display("FAIL rst_clear_now: got %b required 0", VgaWrEn); else passed++;
    n = wq.size();
    repeat (2) @(posedge QClk);
    #3 Reset = 1'b0;
    repeat (20) @(posedge QClk);
    #1;
    total++; if (wq.size() !== n) $display("FAIL rst_clear_nowrite: got %0d writes required %0d", wq.size(), n); else passed++;
    total++; if (CmdReady !== 1'b1) $display("FAIL rst_clear_ready: got %b required 1", CmdReady); else passed++;
    test_char_basic();
  endtask

  task automatic test_back_to_back();
    localparam int N = 5;
    logic [7:0] codes[N];
    logic       invs[N];
    int         cols[N], rows[N], acc_edge[N];
    int         done;
    bit         got;
    ready_mode = 2;
    wq.delete();
    for (int i = 0; i < N; i++) begin
      codes[i] = 8'($urandom); invs[i] = 1'($urandom_range(0, 1));
      cols[i] = int'($urandom_range(0, 79)); rows[i] = int'($urandom_range(0, 59));
    end
    CmdValid = 1'b1;
    for (int i = 0; i < N; i++) begin
      CmdOp = 2'd0; CmdChar = codes[i]; CmdCol = 7'(cols[i]); CmdRow = 6'(rows[i]); CmdInv = invs[i];
      got = 0;
      for (int t = 0; t < 300; t++) begin
        @(negedge QClk);
        if (CmdReady) begin got = 1; break; end
      end
      acc_edge[i] = cyc + 1;
      @(posedge QClk); #1;
      if (!got) begin total++; $display("FAIL b2b_accept%0d: CmdReady got 0 required 1", i); end
    end
    CmdValid = 1'b0;
    wait_idle(300, done);
    total++; if (wq.size() !== 2 * N) $display("FAIL b2b_count: got %0d writes required %0d", wq.size(), 2 * N); else passed++;
    if (wq.size() == 2 * N) begin
      for (int i = 0; i < N; i++) begin
        total++; if (wq[2*i].addr !== 14'(exp_addr(cols[i], rows[i], 0)) || wq[2*i].data !== exp_word(codes[i], 0, invs[i]))
          $display("FAIL b2b_top%0d: got %0d/%h required %0d/%h", i, wq[2*i].addr, wq[2*i].data, exp_addr(cols[i], rows[i], 0), exp_word(codes[i], 0, invs[i])); else passed++;
        total++; if (wq[2*i+1].addr !== 14'(exp_addr(cols[i], rows[i], 1)) || wq[2*i+1].data !== exp_word(codes[i], 4, invs[i]))
          $display("FAIL b2b_bot%0d: got %0d/%h required %0d/%h", i, wq[2*i+1].addr, wq[2*i+1].data, exp_addr(cols[i], rows[i], 1), exp_word(codes[i], 4, invs[i])); else passed++;
        if (i > 0) begin
          total++; if (acc_edge[i] !== wq[2*i-1].edge_n + 1)
            $display("FAIL b2b_accept_edge%0d: got edge %0d required %0d", i, acc_edge[i], wq[2*i-1].edge_n + 1); else passed++;
        end
      end
    end
    ready_mode = 0;
  endtask

  task automatic test_byte_enable();
    total++; if (be_bad !== 0) $display("FAIL byte_enable: got %0d bad cycles required 0", be_bad); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_char_basic();
    test_corner_inv();
    test_oob();
    test_stall();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    test_byte_enable();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
